// File: rtl/bcd_to_binary_seq.sv
// Sequential 4-digit BCD to binary converter, MSD-first multiply-by-10 accumulate.
// Optional digit range check enabled by defining BCD_CHECK_EN.
module bcd_to_binary_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       thos,
  input  logic [3:0]       hund,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] binary,
  output logic             err
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state_q, state_d;
  logic [15:0]        dig_q, dig_d;
  logic [BIN_W+3:0]   acc_q, acc_d, acc_nxt;
  logic [1:0]         idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [3:0]         digit;
  logic               last;

  assign digit   = dig_q[{idx_q, 2'b00} +: 4];
  assign acc_nxt = (acc_q << 3) + (acc_q << 1)
                 + {{BIN_W{1'b0}}, digit};
  assign last    = (state_q == CALC) && (idx_q == 2'd0);

`ifdef BCD_CHECK_EN
  logic err_q, err_d;
  logic bad;

  assign bad = (dig_q[15:12] > 4'd9) || (dig_q[11:8] > 4'd9)
            || (dig_q[7:4] > 4'd9) || (dig_q[3:0] > 4'd9);
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dig_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
`ifdef BCD_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
`ifdef BCD_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dig_d  = dig_q;
    acc_d  = acc_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    bin_d  = bin_q;
`ifdef BCD_CHECK_EN
    err_d  = err_q;
`endif
    if (state_q == IDLE && start) begin
      dig_d  = {thos, hund, tens, ones};
      acc_d  = '0;
      idx_d  = 2'd3;
      busy_d = 1'b1;
    end
    if (state_q == CALC) begin
      acc_d = acc_nxt;
      idx_d = idx_q - 2'd1;
      if (last) begin
        busy_d = 1'b0;
        done_d = 1'b1;
`ifdef BCD_CHECK_EN
        err_d  = bad;
        bin_d  = bad ? '0 : acc_nxt[BIN_W-1:0];
`else
        bin_d  = acc_nxt[BIN_W-1:0];
`endif
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign binary = bin_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Randomized self-checking bench for bcd_to_binary_seq.
// Reference is plain decimal arithmetic; honours BCD_CHECK_EN like the DUT.
module tb_bcd_to_binary_seq;

  localparam int BIN_W = 14;

  logic             clk;
  logic             reset;
  logic             start;
  logic [3:0]       thos, hund, tens, ones;
  logic             busy, done, err;
  logic [BIN_W-1:0] binary;

  int n_chk;
  int n_pass;

  bcd_to_binary_seq #(.BIN_W(BIN_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .thos   (thos),
    .hund   (hund),
    .tens   (tens),
    .ones   (ones),
    .busy   (busy),
    .done   (done),
    .binary (binary),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_conv(
    input  int               th, h, t, o,
    output logic [BIN_W-1:0] b,
    output logic             e
  );
    int v;
    v = th * 1000 + h * 100 + t * 10 + o;
    b = BIN_W'(v % (1 << BIN_W));
    e = 1'b0;
`ifdef BCD_CHECK_EN
    if (th > 9 || h > 9 || t > 9 || o > 9) begin
      e = 1'b1;
      b = '0;
    end
`endif
  endfunction

  // One full conversion with cycle-exact handshake checks.
  // Entered and left while the DUT is idle, away from the rising edge.
  task automatic do_conv(
    input int    th, h, t, o,
    input bit    chg,
    input string nm
  );
    logic [BIN_W-1:0] eb;
    logic             ee;
    ref_conv(th, h, t, o, eb, ee);
    thos  = 4'(th);
    hund  = 4'(h);
    tens  = 4'(t);
    ones  = 4'(o);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (chg) begin
      thos = 4'd8; hund = 4'd8; tens = 4'd8; ones = 4'd8;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b1 || done !== 1'b0)
        $display("FAIL %s busy cyc%0d: busy=%b done=%b want busy=1 done=0",
                 nm, i, busy, done);
      else n_pass++;
      @(posedge clk);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s done pulse: done=%b busy=%b want 1/0",
               nm, done, busy);
    else n_pass++;
    n_chk++;
    if (binary !== eb || err !== ee)
      $display("FAIL %s result: binary=%0d err=%b want %0d/%b",
               nm, binary, err, eb, ee);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || binary !== eb || err !== ee)
      $display("FAIL %s hold: done=%b binary=%0d err=%b want 0/%0d/%b",
               nm, done, binary, err, eb, ee);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    thos = 0; hund = 0; tens = 0; ones = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 0 || done !== 0 || binary !== 0 || err !== 0)
      $display("FAIL reset: busy=%b done=%b bin=%0d err=%b want all 0",
               busy, done, binary, err);
    else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 0 || done !== 0 || binary !== 0)
      $display("FAIL post_reset: busy=%b done=%b bin=%0d want 0",
               busy, done, binary);
    else n_pass++;
  endtask

  task automatic test_basic;
    do_conv(1, 2, 3, 4, 1'b0, "c1234");
    do_conv(9, 9, 9, 9, 1'b0, "c9999");
    do_conv(0, 0, 0, 0, 1'b0, "c0000");
  endtask

  task automatic test_digit_change;
    do_conv(1, 2, 3, 4, 1'b1, "chg1234");
  endtask

  task automatic test_bad_digit;
    do_conv(1, 2, 10, 4, 1'b0, "tensA");
    do_conv(15, 0, 0, 12, 1'b0, "thosF");
  endtask

  // Start held for 12 edges; a busy DUT must ignore it.
  task automatic test_held;
    int next_free;
    int done_at;
    int pulses;
    logic eb_busy, eb_done;
    next_free = 0;
    done_at = -1;
    pulses = 0;
    thos = 0; hund = 0; tens = 5; ones = 7;
    start = 1'b1;
    for (int c = 0; c < 17; c++) begin
      @(posedge clk);
      if (c < 12 && c >= next_free) begin
        done_at = c + 4;
        next_free = c + 5;
      end
      #1 if (c == 11) start = 1'b0;
      eb_done = (c == done_at);
      eb_busy = (c < done_at);
      @(negedge clk);
      n_chk++;
      if (done !== eb_done || busy !== eb_busy)
        $display("FAIL held cyc%0d: done=%b busy=%b want %b/%b",
                 c, done, busy, eb_done, eb_busy);
      else n_pass++;
      if (done === 1'b1) begin
        pulses++;
        n_chk++;
        if (binary !== 57)
          $display("FAIL held bin cyc%0d: %0d want 57", c, binary);
        else n_pass++;
      end
    end
    n_chk++;
    if (pulses != 3)
      $display("FAIL held pulses: %0d want 3", pulses);
    else n_pass++;
  endtask

  task automatic test_random;
    int d [4];
    for (int n = 0; n < 20; n++) begin
      for (int j = 0; j < 4; j++)
        d[j] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15))
                                           : int'($urandom_range(0, 9));
      do_conv(d[0], d[1], d[2], d[3], 1'b0, "rand");
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulses = 0;
    thos = 1; hund = 2; tens = 3; ones = 4;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 0 || done !== 0 || binary !== 0 || err !== 0)
      $display("FAIL reset_mid: busy=%b done=%b bin=%0d err=%b want 0",
               busy, done, binary, err);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) pulses++;
    end
    n_chk++;
    if (pulses != 0 || binary !== 0)
      $display("FAIL reset_mid after: bad_cycles=%0d bin=%0d want 0/0",
               pulses, binary);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset();
    test_basic();
    test_digit_change();
    test_bad_digit();
    test_held();
    test_random();
    do_conv(4, 3, 2, 1, 1'b0, "pre_rst");
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
